// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: RV32IM execution unit, single-cycle base ALU plus iterative multiply/divide.
// Define ALU_MDU_FAST_MUL_EN for a single-cycle multiplier; divides stay iterative either way.
module alu_mdu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] operand_1,
    input  logic [XLEN-1:0] operand_2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALU_result,
    output logic            zero
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CW = SHW + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        r_state;
    logic [XLEN-1:0]   r_result;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_opd;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_f3;
    logic              r_neg;

    logic              w_accept;
    logic [SHW-1:0]    w_shamt;
    logic              w_slt;
    logic              w_sltu;
    logic [XLEN-1:0]   w_base;
    logic [2:0]        w_f3;
    logic              w_sgn1;
    logic              w_sgn2;
    logic              w_neg1;
    logic              w_neg2;
    logic              w_res_neg;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic              w_div0;
    logic              w_ovf;
    logic              w_iter;
    logic [XLEN-1:0]   w_comb;
    logic [XLEN:0]     w_shl;
    logic [XLEN:0]     w_trial;
    logic [XLEN:0]     w_sum;
    logic [XLEN-1:0]   w_hi_nxt;
    logic [XLEN-1:0]   w_lo_nxt;
    logic [2*XLEN-1:0] w_prod_it;
    logic [2*XLEN-1:0] w_prod_sc;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_iter_res;

    assign in_ready   = !rst && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = (r_state == S_DONE);
    assign ALU_result = r_result;
    assign zero       = (r_result == '0);

    assign w_shamt = operand_2[SHW-1:0];
    assign w_slt   = $signed(operand_1) < $signed(operand_2);
    assign w_sltu  = operand_1 < operand_2;

    always_comb begin
        w_base = '0;
        case (op[3:0])
            4'b0000: w_base = {{(XLEN-1){1'b0}}, w_slt};
            4'b0001: w_base = operand_1 + operand_2;
            4'b0010: w_base = operand_1 - operand_2;
            4'b0011: w_base = operand_1 & operand_2;
            4'b0100: w_base = operand_1 | operand_2;
            4'b0101: w_base = operand_1 << w_shamt;
            4'b0110: w_base = operand_1 >> w_shamt;
            4'b0111: w_base = operand_1 ^ operand_2;
            4'b1010: w_base = $unsigned($signed(operand_1) >>> w_shamt);
            4'b1011: w_base = {{(XLEN-1){1'b0}}, w_sltu};
            default: w_base = '0;
        endcase
    end

    // Operands become magnitudes; r_neg records the single sign fix-up applied at the end.
    assign w_f3      = op[2:0];
    assign w_sgn1    = (w_f3 == 3'b001) || (w_f3 == 3'b010) || (w_f3 == 3'b100) || (w_f3 == 3'b110);
    assign w_sgn2    = (w_f3 == 3'b001) || (w_f3 == 3'b100) || (w_f3 == 3'b110);
    assign w_neg1    = w_sgn1 && operand_1[XLEN-1];
    assign w_neg2    = w_sgn2 && operand_2[XLEN-1];
    assign w_mag1    = w_neg1 ? -operand_1 : operand_1;
    assign w_mag2    = w_neg2 ? -operand_2 : operand_2;
    assign w_res_neg = (w_f3 == 3'b110) ? w_neg1 : (w_neg1 ^ w_neg2);
    assign w_div0    = (operand_2 == '0);
    assign w_ovf     = w_sgn1 && (operand_1 == MOST_NEG) && (operand_2 == '1);

`ifdef ALU_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fprod;
    assign w_fprod = {{XLEN{w_sgn1 && operand_1[XLEN-1]}}, operand_1}
                   * {{XLEN{w_sgn2 && operand_2[XLEN-1]}}, operand_2};
`endif

    always_comb begin
        w_iter = 1'b0;
        w_comb = w_base;
        if (op[4]) begin
            if (w_f3[2]) begin
                if (w_div0)
                    w_comb = w_f3[1] ? operand_1 : '1;
                else if (w_ovf)
                    w_comb = w_f3[1] ? '0 : operand_1;
                else
                    w_iter = 1'b1;
            end else begin
`ifdef ALU_MDU_FAST_MUL_EN
                w_comb = (w_f3 == 3'b000) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`else
                w_iter = 1'b1;
`endif
            end
        end
    end

    // One restoring-divide step ({r_hi,r_lo} = remainder/quotient) or one shift-add step.
    always_comb begin
        w_shl   = {r_hi, r_lo[XLEN-1]};
        w_trial = w_shl - {1'b0, r_opd};
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
        w_hi_nxt = w_sum[XLEN:1];
        w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
        if (r_f3[2]) begin
            if (w_trial[XLEN]) begin
                w_hi_nxt = w_shl[XLEN-1:0];
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
            end else begin
                w_hi_nxt = w_trial[XLEN-1:0];
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
            end
        end
    end

    always_comb begin
        w_prod_it = {w_hi_nxt, w_lo_nxt};
        w_prod_sc = r_neg ? -w_prod_it : w_prod_it;
        w_quo     = r_neg ? -w_lo_nxt : w_lo_nxt;
        w_rem     = r_neg ? -w_hi_nxt : w_hi_nxt;
        case (r_f3)
            3'b000:                 w_iter_res = w_prod_sc[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_iter_res = w_prod_sc[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_iter_res = w_quo;
            default:                w_iter_res = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opd    <= '0;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_neg    <= 1'b0;
        end else if (r_state == S_BUSY) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_result <= w_iter_res;
                r_state  <= S_DONE;
            end
        end else if (w_accept) begin
            if (w_iter) begin
                r_state <= S_BUSY;
                r_cnt   <= CW'(XLEN);
                r_f3    <= w_f3;
                r_neg   <= w_res_neg;
                r_hi    <= '0;
                r_lo    <= w_f3[2] ? w_mag1 : w_mag2;
                r_opd   <= w_f3[2] ? w_mag2 : w_mag1;
            end else begin
                r_result <= w_comb;
                r_state  <= S_DONE;
            end
        end else if ((r_state != S_DONE) || out_ready) begin
            r_state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb_alu_mdu_seq: directed and randomized checks of alu_mdu_seq against a behavioural model.
// Honours ALU_MDU_FAST_MUL_EN for expected multiply latency.
`timescale 1ns/1ps
module tb_alu_mdu_seq;
    localparam int XLEN = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;
`ifdef ALU_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam logic [4:0] OP_SLT = 5'b00000, OP_ADD = 5'b00001, OP_SUB = 5'b00010;
    localparam logic [4:0] OP_SRA = 5'b01010, OP_SLTU = 5'b01011;
    localparam logic [4:0] OP_MUL = 5'b10000, OP_MULH = 5'b10001, OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU = 5'b10011, OP_DIV = 5'b10100, OP_DIVU = 5'b10101;
    localparam logic [4:0] OP_REM = 5'b10110, OP_REMU = 5'b10111;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, zero;
    logic [4:0]  op;
    logic [31:0] operand_1, operand_2, ALU_result;

    alu_mdu_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .operand_1(operand_1), .operand_2(operand_2), .out_valid(out_valid),
        .out_ready(out_ready), .ALU_result(ALU_result), .zero(zero)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        longint             sa, sb;
        logic [63:0]        p;
        logic signed [31:0] as;
        logic [31:0]        r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        as = a;
        r  = '0;
        if (!o[4]) begin
            case (o[3:0])
                4'd0:    r = (sa < sb) ? 32'd1 : 32'd0;
                4'd1:    r = a + b;
                4'd2:    r = a - b;
                4'd3:    r = a & b;
                4'd4:    r = a | b;
                4'd5:    r = a << b[4:0];
                4'd6:    r = a >> b[4:0];
                4'd7:    r = a ^ b;
                4'd10:   r = as >>> b[4:0];
                4'd11:   r = (a < b) ? 32'd1 : 32'd0;
                default: r = '0;
            endcase
        end else begin
            case (o[2:0])
                3'd0: begin p = sa * sb; r = p[31:0]; end
                3'd1: begin p = sa * sb; r = p[63:32]; end
                3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
                3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
                3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (a == MIN && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
                3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: r = (b == 0) ? a : (a == MIN && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
                default: r = (b == 0) ? a : a % b;
            endcase
        end
        return r;
    endfunction

    function automatic int lat_of(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        if (!o[4]) return 1;
        if (o[2]) return (b == 0 || (!o[0] && a == MIN && b == 32'hFFFF_FFFF)) ? 1 : 33;
        return MUL_LAT;
    endfunction

    // Scoreboard: each accepted op is due at accept-cycle + latency and held until taken.
    typedef struct { logic [31:0] res; int rdy; int acc; int lat; bit seen; } exp_t;
    exp_t        q[$];
    exp_t        h;
    int          k = 0;
    bit          post_rst = 1'b0;
    bit          ev, eir;
    logic [31:0] last_res = '0;
    logic        last_zero = 1'b0;
    int          last_lat = 0;

    always begin
        @(negedge clk); #3;
        k++;
        if (rst) begin
            chk("in_ready_during_rst", 32'(in_ready), 32'd0);
            q.delete();
            post_rst = 1'b1;
        end else begin
            if (post_rst) begin
                chk("rst_result", ALU_result, 32'd0);
                chk("rst_zero", 32'(zero), 32'd1);
                post_rst = 1'b0;
            end
            ev = 1'b0;
            if (q.size() > 0) ev = (k >= q[0].rdy);
            chk("out_valid", 32'(out_valid), 32'(ev));
            if (ev) begin
                h = q[0];
                chk("ALU_result", ALU_result, h.res);
                chk("zero", 32'(zero), 32'(h.res == 0));
                if (!h.seen) begin
                    h.seen = 1'b1;
                    h.lat  = k - h.acc;
                    q[0]   = h;
                end
            end
            eir = (q.size() == 0) || (ev && out_ready);
            chk("in_ready", 32'(in_ready), 32'(eir));
            if (ev && out_ready) begin
                last_res  = ALU_result;
                last_zero = zero;
                last_lat  = q[0].lat;
                void'(q.pop_front());
            end
            if (in_valid && eir) begin
                h.res  = model(op, operand_1, operand_2);
                h.acc  = k;
                h.rdy  = k + lat_of(op, operand_1, operand_2);
                h.lat  = 0;
                h.seen = 1'b0;
                q.push_back(h);
            end
        end
    end

    bit rnd_ready = 1'b0;
    bit fix_ready = 1'b1;

    function automatic logic pick_ready();
        return rnd_ready ? ($urandom_range(0, 3) != 0) : fix_ready;
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] t;
        t = $urandom_range(1, 40);
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return MIN;
            4:       return t;
            5:       return -t;
            default: return $urandom;
        endcase
    endfunction

    task automatic idle_cycle();
        @(negedge clk); #1;
        in_valid  = 1'b0;
        op        = 5'($urandom);
        operand_1 = $urandom;
        operand_2 = $urandom;
        out_ready = pick_ready();
    endtask

    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        bit ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk); #1;
            in_valid  = 1'b1;
            op        = o;
            operand_1 = a;
            operand_2 = b;
            out_ready = pick_ready();
            #1;
            ok = in_ready;
        end
        if (!ok) fail_now("issue_accept");
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int n = 0; n < 120 && !ok; n++) begin
            idle_cycle();
            #3;
            ok = (q.size() == 0);
        end
        if (!ok) fail_now("result_done");
    endtask

    task automatic directed(input string nm, input logic [4:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] er, input int el);
        issue(o, a, b);
        wait_done();
        chk(nm, last_res, er);
        chk({nm, "_latency"}, 32'(last_lat), 32'(el));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_valid;
        rst = 1'b1; in_valid = 1'b0; op = '0; operand_1 = '0; operand_2 = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        directed("add_ovf",  OP_ADD,  32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);
        directed("sra",      OP_SRA,  32'h8000_0000, 32'h24, 32'hF800_0000, 1);
        directed("slt",      OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        directed("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        directed("sub_zero", OP_SUB,  32'd5, 32'd5, 32'd0, 1);
        chk("sub_zero_flag", 32'(last_zero), 32'd1);
        directed("div_neg",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        directed("rem_neg",  OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        directed("divu",     OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        directed("div_by0",  OP_DIV,  32'd12345, 32'd0, 32'hFFFF_FFFF, 1);
        directed("remu_by0", OP_REMU, 32'd9, 32'd0, 32'd9, 1);
        directed("div_ovf",  OP_DIV,  MIN, 32'hFFFF_FFFF, MIN, 1);
        directed("rem_ovf",  OP_REM,  MIN, 32'hFFFF_FFFF, 32'd0, 1);
        directed("mulh",     OP_MULH,   MIN, MIN, 32'h4000_0000, MUL_LAT);
        directed("mulhu",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        directed("mulhsu",   OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT);
        directed("mul",      OP_MUL,    32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFF4, MUL_LAT);

        // Backpressure in DONE, then release together with a new request.
        fix_ready = 1'b0;
        issue(OP_ADD, 32'd10, 32'd20);
        seen_valid = 1'b0;
        for (int n = 0; n < 5 && !seen_valid; n++) begin
            idle_cycle();
            #3;
            seen_valid = out_valid;
        end
        if (!seen_valid) fail_now("bp_out_valid");
        for (int n = 0; n < 5; n++) begin
            idle_cycle();
            #3;
            chk("bp_hold_result", ALU_result, 32'd30);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        fix_ready = 1'b1;
        directed("b2b_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1);

        // Reset in the middle of an iterative divide.
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) idle_cycle();
        @(negedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        #3;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", ALU_result, 32'd0);
        chk("midrst_zero", 32'(zero), 32'd1);
        directed("add_after_rst", OP_ADD, 32'd1, 32'd1, 32'd2, 1);

        rnd_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            issue(5'($urandom), rnd_val(), rnd_val());
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        rnd_ready = 1'b0;
        fix_ready = 1'b1;
        wait_done();
        repeat (3) idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Parametrised, handshaked execution unit for the RV32IM datapath.
- Performs all base integer ALU operations plus the RV32M multiply/divide group.
- Sits between the decode/operand-fetch stage and writeback, behind a valid/ready interface so multi-cycle M-ops can stall the pipeline.
- Base ops complete in one cycle; divides, and multiplies unless fast multiply is compiled in, are iterative.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, 8 or greater.
- SHW, $clog2(XLEN), shift-amount width, derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request this cycle
- op  in  5  op[4]=0: base op in op[3:0]; op[4]=1: M-op, funct3 in op[2:0]
- operand_1  in  XLEN  rs1 value
- operand_2  in  XLEN  rs2 value or immediate
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- ALU_result  out  XLEN  registered result
- zero  out  1  ALU_result == 0

Behaviour:
- Base op encodings (op[3:0]):
  - SLT=0000, ADD=0001, SUB=0010, AND=0011, OR=0100
  - SLL=0101, SRL=0110, XOR=0111, SRA=1010, SLTU=1011
  - any other value gives result 0
- Shifts use operand_2[SHW-1:0]. SLT is signed compare, SLTU unsigned; both give 0 or 1 zero-extended.
- M-op funct3 encodings:
  - MUL=000, MULH=001, MULHSU=010, MULHU=011
  - DIV=100, DIVU=101, REM=110, REMU=111
- MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN product, with RISC-V signedness.
- Division special cases, resolved with base-op latency (no iteration):
  - divisor 0: DIV/DIVU give all-ones, REM/REMU give operand_1.
  - signed overflow (most-negative / -1): DIV gives operand_1, REM gives 0.
- Signed divide: magnitudes go through an unsigned restoring divider. Quotient is negated when operand signs differ; remainder takes operand_1's sign.
- FSM states: IDLE, BUSY, DONE.
  - Accept = in_valid && in_ready; operands and op are captured on the accepting edge.
  - IDLE, accept of base op or special-case div: go to DONE; result is valid after 1 edge.
  - IDLE, accept of iterative op: go to BUSY and load counter = XLEN. Each BUSY cycle does one shift-add or restore step and decrements the counter. At counter 1 go to DONE. out_valid rises XLEN+1 edges after accept.
  - DONE: out_valid=1. ALU_result and zero hold stable until out_ready.
  - DONE, out_ready=1 and no new accept: go to IDLE.
  - DONE, out_ready=1 and accept: follow the IDLE transition for the new op (back-to-back, no bubble).
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is 0 in BUSY.
- Operand inputs are ignored while not accepting, including changes during BUSY.
- zero is combinational from the registered ALU_result.
- Reset, including mid-BUSY:
  - state goes to IDLE and any in-flight op is discarded with no out_valid.
  - ALU_result=0, out_valid=0, counter=0, internal accumulators=0.
  - zero=1, in_ready=0 during the cycle rst is high, 1 after.

Optional Feature:
- Macro ALU_MDU_FAST_MUL_EN.
- When defined: MUL/MULH/MULHSU/MULHU use a single-cycle 2*XLEN multiply from sign/zero-extended operands, with base-op latency (result after 1 edge). Divides stay iterative.
- When undefined: all multiplies use an iterative shift-add over magnitudes with final sign correction, with XLEN+1 edge latency (same as divides).
- Results are bit-identical either way; only latency differs.

Test Plan:
- Base ops, XLEN=32, out_ready=1:
  - ADD 0x7FFFFFFF+1 -> 0x80000000 after 1 edge.
  - SRA 0x80000000 by 0x24 -> shift by 4 -> 0xF8000000.
  - SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
  - SUB 5-5 -> 0 with zero=1.
- Divide: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14. out_valid rises exactly 33 edges after accept; in_ready=0 throughout BUSY.
- Divide special cases: DIV x/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of that pair -> 0. Each valid after 1 edge.
- Multiply: MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF; MUL 3*-4 -> 0xFFFFFFF4. Latency is 1 edge with ALU_MDU_FAST_MUL_EN, 33 edges without.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE -> ALU_result stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 (ADD 2+3) in the same cycle -> new result 5 on the next edge, no idle bubble.
- Reset mid-operation: assert rst at BUSY cycle 10 of a DIVU -> next edge state IDLE, out_valid=0, ALU_result=0, zero=1. A following ADD 1+1 -> 2 after 1 edge.
